// File: rtl/fifo_pkg.sv
// Shared sizing helpers for the convolution-datapath FIFO.
package fifo_pkg;

    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned DEF_FIFO_DEPTH = 16;
    localparam int unsigned DEF_PTR_W      = ptr_width(DEF_FIFO_DEPTH);

    typedef logic [DEF_PTR_W-1:0] count_t;

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port RAM: synchronous write, registered synchronous read.
module fifo_mem #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned ADDR_W     = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_wr_en,
    input  logic [ADDR_W-1:0]     i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_en,
    input  logic [ADDR_W-1:0]     i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Read-before-write: a same-address write on this edge is not visible here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/async_fifo.sv
// Single-clock FIFO with wrap-bit pointers, occupancy and debug error pulses.
module async_fifo
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wr_en,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    input  logic                          rd_en,
    output logic [DATA_WIDTH-1:0]         rd_data,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int unsigned PTR_W = ptr_width(FIFO_DEPTH);
    localparam int unsigned AW    = PTR_W - 1;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("async_fifo: FIFO_DEPTH must be a power of two >= 2");
    end

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic             r_overflow;
    logic             r_underflow;
    logic             w_empty;
    logic             w_full;
    logic             w_rd_acc;
    logic             w_wr_acc;

    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full   = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign w_rd_acc = rd_en && !w_empty;
    // A pop on a full FIFO frees the slot the concurrent push lands in.
    assign w_wr_acc = wr_en && (!w_full || w_rd_acc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_overflow  <= wr_en && w_full && !w_rd_acc;
            r_underflow <= rd_en && w_empty;
        end
    end

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH),
        .ADDR_W     (AW)
    ) u_mem (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_wr_en    (w_wr_acc),
        .i_wr_addr  (r_wr_ptr[AW-1:0]),
        .i_wr_data  (wr_data),
        .i_rd_en    (w_rd_acc),
        .i_rd_addr  (r_rd_ptr[AW-1:0]),
        .o_rd_data  (rd_data)
    );

    assign full      = w_full;
    assign empty     = w_empty;
    assign count     = r_wr_ptr - r_rd_ptr;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule

// File: tb/tb_async_fifo.sv
// Directed self-checking bench for async_fifo (DATA_WIDTH=8, FIFO_DEPTH=16).
module tb_async_fifo;
    import fifo_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = '0;
    logic       rd_en = 1'b0;
    logic [7:0] rd_data;
    logic       full;
    logic       empty;
    count_t     count;
    logic       overflow;
    logic       underflow;

    int checks = 0;
    int errors = 0;

    async_fifo #(
        .DATA_WIDTH (8),
        .FIFO_DEPTH (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    task automatic step(input logic w, input logic [7:0] d, input logic r);
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (empty !== 1'b1 || full !== 1'b0 || count !== 5'd0 || rd_data !== 8'h00 ||
            overflow !== 1'b0 || underflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: empty=%b full=%b count=%0d rd_data=%h ovf=%b unf=%b want 1 0 0 00 0 0",
                     empty, full, count, rd_data, overflow, underflow);
        end
        rst_n = 1'b1;
        step(1'b0, 8'h00, 1'b0);
        checks++;
        if (empty !== 1'b1 || full !== 1'b0 || count !== 5'd0 || rd_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_release: empty=%b full=%b count=%0d rd_data=%h want 1 0 0 00",
                     empty, full, count, rd_data);
        end
    endtask

    task automatic test_fill;
        for (int i = 1; i <= 16; i++) begin
            step(1'b1, 8'(i), 1'b0);
            checks++;
            if (count !== 5'(i) || full !== (i == 16) || empty !== 1'b0 || overflow !== 1'b0) begin
                errors++;
                $display("FAIL fill_%0d: count=%0d full=%b empty=%b ovf=%b want count=%0d full=%b empty=0 ovf=0",
                         i, count, full, empty, overflow, i, (i == 16));
            end
        end
        step(1'b1, 8'hAA, 1'b0);
        checks++;
        if (overflow !== 1'b1 || count !== 5'd16 || full !== 1'b1) begin
            errors++;
            $display("FAIL overflow_pulse: ovf=%b count=%0d full=%b want 1 16 1", overflow, count, full);
        end
        step(1'b0, 8'h00, 1'b0);
        checks++;
        if (overflow !== 1'b0 || count !== 5'd16) begin
            errors++;
            $display("FAIL overflow_clear: ovf=%b count=%0d want 0 16", overflow, count);
        end
    endtask

    task automatic test_drain;
        for (int i = 1; i <= 16; i++) begin
            step(1'b0, 8'h00, 1'b1);
            checks++;
            if (rd_data !== 8'(i) || count !== 5'(16 - i) || underflow !== 1'b0) begin
                errors++;
                $display("FAIL drain_%0d: rd_data=%h count=%0d unf=%b want %h %0d 0",
                         i, rd_data, count, underflow, 8'(i), 16 - i);
            end
        end
        checks++;
        if (empty !== 1'b1 || full !== 1'b0) begin
            errors++;
            $display("FAIL drain_empty: empty=%b full=%b want 1 0", empty, full);
        end
        step(1'b0, 8'h00, 1'b1);
        checks++;
        if (underflow !== 1'b1 || rd_data !== 8'h10 || count !== 5'd0) begin
            errors++;
            $display("FAIL underflow_pulse: unf=%b rd_data=%h count=%0d want 1 10 0", underflow, rd_data, count);
        end
        step(1'b0, 8'h00, 1'b0);
        checks++;
        if (underflow !== 1'b0) begin
            errors++;
            $display("FAIL underflow_clear: unf=%b want 0", underflow);
        end
    endtask

    task automatic test_full_rw;
        for (int i = 1; i <= 16; i++) step(1'b1, 8'(i), 1'b0);
        step(1'b1, 8'h55, 1'b1);
        checks++;
        if (overflow !== 1'b0 || count !== 5'd16 || full !== 1'b1 || rd_data !== 8'h01) begin
            errors++;
            $display("FAIL full_rw: ovf=%b count=%0d full=%b rd_data=%h want 0 16 1 01",
                     overflow, count, full, rd_data);
        end
        for (int i = 2; i <= 17; i++) begin
            logic [7:0] exp;
            exp = (i == 17) ? 8'h55 : 8'(i);
            step(1'b0, 8'h00, 1'b1);
            checks++;
            if (rd_data !== exp) begin
                errors++;
                $display("FAIL full_rw_pop_%0d: rd_data=%h want %h", i, rd_data, exp);
            end
        end
        checks++;
        if (empty !== 1'b1 || count !== 5'd0) begin
            errors++;
            $display("FAIL full_rw_empty: empty=%b count=%0d want 1 0", empty, count);
        end
    endtask

    task automatic test_empty_rw;
        step(1'b1, 8'h33, 1'b1);
        checks++;
        if (count !== 5'd1 || underflow !== 1'b1 || rd_data !== 8'h55 || empty !== 1'b0) begin
            errors++;
            $display("FAIL empty_rw: count=%0d unf=%b rd_data=%h empty=%b want 1 1 55 0",
                     count, underflow, rd_data, empty);
        end
        step(1'b0, 8'h00, 1'b1);
        checks++;
        if (rd_data !== 8'h33 || count !== 5'd0 || underflow !== 1'b0) begin
            errors++;
            $display("FAIL empty_rw_pop: rd_data=%h count=%0d unf=%b want 33 0 0", rd_data, count, underflow);
        end
    endtask

    task automatic test_wrap_and_reset;
        logic [7:0] exp_rd;
        exp_rd = 8'h80;
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 8'(8'h80 + i), (i >= 3));
            if (i >= 3) begin
                checks++;
                if (rd_data !== exp_rd || count !== 5'd3) begin
                    errors++;
                    $display("FAIL wrap_%0d: rd_data=%h count=%0d want %h 3", i, rd_data, count, exp_rd);
                end
                exp_rd++;
            end
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'h00, 1'b1);
            checks++;
            if (rd_data !== exp_rd || count !== 5'(2 - i)) begin
                errors++;
                $display("FAIL wrap_tail_%0d: rd_data=%h count=%0d want %h %0d", i, rd_data, count, exp_rd, 2 - i);
            end
            exp_rd++;
        end
        checks++;
        if (empty !== 1'b1) begin
            errors++;
            $display("FAIL wrap_empty: empty=%b want 1", empty);
        end
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'hC0 + i), 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (empty !== 1'b1 || count !== 5'd0 || rd_data !== 8'h00 || full !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: empty=%b count=%0d rd_data=%h full=%b want 1 0 00 0",
                     empty, count, rd_data, full);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b0, 8'h00, 1'b1);
        checks++;
        if (underflow !== 1'b1 || empty !== 1'b1 || rd_data !== 8'h00) begin
            errors++;
            $display("FAIL post_reset_pop: unf=%b empty=%b rd_data=%h want 1 1 00", underflow, empty, rd_data);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_full_rw();
        test_empty_rw();
        test_wrap_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: sim time exceeded, want completion");
        $fatal(1, "timeout");
    end

endmodule
